// File: rtl/arm_pipe_pkg.sv
// Shared types for the ARM pipeline hazard controller: wait-FSM state encoding,
// default SRAM access length and the stage-control bundle.
package arm_pipe_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } wait_state_t;

  localparam int MEM_WAIT_DEF = 4;

  // Field order matches the top-level output list, MSB first.
  typedef struct packed {
    logic freeze_pc;
    logic freeze_if_id;
    logic flush_if_id;
    logic freeze_id_ex;
    logic flush_id_ex;
    logic freeze_exe_mem;
    logic flush_mem_wb;
  } stage_ctrl_t;

endpackage

// File: rtl/sram_wait_counter.sv
// Wait-state FSM for a multi-cycle SRAM access in the MEM stage.
// Stalls for exactly MEM_WAIT cycles, then spends one busy release cycle.
module sram_wait_counter
  import arm_pipe_pkg::*;
#(
  parameter int MEM_WAIT = MEM_WAIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_req,
  output logic mem_stall,
  output logic mem_busy
);

  // state | meaning
  // IDLE  | no access in flight; a mem_req starts one and stalls this cycle
  // WAIT  | access in flight; stall while cnt!=0, cnt==0 is the release cycle
  localparam int CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

  wait_state_t   state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_req) begin
            state <= WAIT;
            cnt   <= CW'(MEM_WAIT - 1);
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign mem_stall = ((state == IDLE) && mem_req) || ((state == WAIT) && (cnt != '0));
  assign mem_busy  = (state == WAIT);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage ARM pipeline, with saturating
// performance counters of stall cycles and flush cycles.
module pipe_hazard_ctrl
  import arm_pipe_pkg::*;
#(
  parameter int MEM_WAIT = MEM_WAIT_DEF,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             perf_clr,
  output logic             freeze_pc,
  output logic             freeze_if_id,
  output logic             flush_if_id,
  output logic             freeze_id_ex,
  output logic             flush_id_ex,
  output logic             freeze_exe_mem,
  output logic             flush_mem_wb,
  output logic             mem_busy,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  logic        mem_stall;
  logic        busy_raw;
  stage_ctrl_t ctrl;

  sram_wait_counter #(.MEM_WAIT(MEM_WAIT)) u_wait (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_stall (mem_stall),
    .mem_busy  (busy_raw)
  );

  // A memory stall freezes EXE, so any branch/hazard decision waits for release.
  always_comb begin
    ctrl = '0;
    if (!rst) begin
      if (mem_stall) begin
        ctrl.freeze_pc      = 1'b1;
        ctrl.freeze_if_id   = 1'b1;
        ctrl.freeze_id_ex   = 1'b1;
        ctrl.freeze_exe_mem = 1'b1;
        ctrl.flush_mem_wb   = 1'b1;
      end else if (branch_taken) begin
        ctrl.flush_if_id = 1'b1;
        ctrl.flush_id_ex = 1'b1;
      end else if (hazard) begin
        ctrl.freeze_pc    = 1'b1;
        ctrl.freeze_if_id = 1'b1;
        ctrl.flush_id_ex  = 1'b1;
      end
    end
  end

  assign freeze_pc      = ctrl.freeze_pc;
  assign freeze_if_id   = ctrl.freeze_if_id;
  assign flush_if_id    = ctrl.flush_if_id;
  assign freeze_id_ex   = ctrl.freeze_id_ex;
  assign flush_id_ex    = ctrl.flush_id_ex;
  assign freeze_exe_mem = ctrl.freeze_exe_mem;
  assign flush_mem_wb   = ctrl.flush_mem_wb;
  assign mem_busy       = busy_raw && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else if (perf_clr) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (ctrl.freeze_pc && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
      if (ctrl.flush_if_id && (flush_count != '1)) begin
        flush_count <= flush_count + CNT_W'(1);
      end
    end
  end

endmodule
